// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master.
// Holds the FSM state encoding and the response status codes.
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OKAY    = 2'd0,
        SLVERR  = 2'd1,
        TIMEOUT = 2'd2
    } status_e;

endpackage

// File: rtl/rggen_apb_if.sv
// APB bus bundle with master and slave views.
// Ports: psel/penable/paddr/pprot/pwrite/pstrb/pwdata (m->s), pready/prdata/pslverr (s->m).
interface rggen_apb_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                       psel;
    logic                       penable;
    logic [ADDRESS_WIDTH-1:0]   paddr;
    logic [2:0]                 pprot;
    logic                       pwrite;
    logic [BUS_WIDTH/8-1:0]     pstrb;
    logic [BUS_WIDTH-1:0]       pwdata;
    logic                       pready;
    logic [BUS_WIDTH-1:0]       prdata;
    logic                       pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Turns single valid/ready commands into APB transfers, one at a time.
// Ports: i_clk, i_rst (sync, high); cmd_* request; rsp_* response; apb_if master port.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_wdata,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [BUS_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]               o_rsp_status,
    rggen_apb_if.master              apb_if
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(3);

    state_e           state;
    logic [CNT_W-1:0] wait_count;
    logic             timeout_hit;

    // Only checked when pready is low, so a late pready still wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_count == TO_VAL);

    assign o_cmd_ready  = (state == IDLE);
    assign apb_if.pprot = 3'b000;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            wait_count     <= '0;
            apb_if.psel    <= 1'b0;
            apb_if.penable <= 1'b0;
            apb_if.paddr   <= '0;
            apb_if.pwrite  <= 1'b0;
            apb_if.pstrb   <= '0;
            apb_if.pwdata  <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_rdata    <= '0;
            o_rsp_status   <= OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        apb_if.psel   <= 1'b1;
                        apb_if.paddr  <= i_cmd_address & ADDR_MASK;
                        apb_if.pwrite <= i_cmd_write;
                        apb_if.pwdata <= i_cmd_wdata;
                        apb_if.pstrb  <= i_cmd_write ? i_cmd_strobe : '0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    apb_if.penable <= 1'b1;
                    wait_count     <= '0;
                    state          <= ACCESS;
                end
                ACCESS: begin
                    if (apb_if.pready) begin
                        apb_if.psel    <= 1'b0;
                        apb_if.penable <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        o_rsp_rdata    <= apb_if.pwrite ? '0 : apb_if.prdata;
                        o_rsp_status   <= apb_if.pslverr ? SLVERR : OKAY;
                        state          <= RESP;
                    end else if (timeout_hit) begin
                        apb_if.psel    <= 1'b0;
                        apb_if.penable <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        o_rsp_rdata    <= '0;
                        o_rsp_status   <= TIMEOUT;
                        state          <= RESP;
                    end else begin
                        wait_count <= wait_count + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master with a behavioural APB slave and reference model.
// Runs directed scenarios then randomized transfers with TIMEOUT_CYCLES=4.
module tb_apb_cmd_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    int checks = 0;
    int fails  = 0;

    rggen_apb_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) apb ();

    apb_cmd_master #(
        .ADDRESS_WIDTH(16),
        .BUS_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_write(cmd_write),
        .i_cmd_address(cmd_addr),
        .i_cmd_wdata(cmd_wdata),
        .i_cmd_strobe(cmd_strb),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_status(rsp_status),
        .apb_if(apb)
    );

    always #5 clk = ~clk;

    // Observations from the last transfer
    bit          o_ready_start, o_ready_busy, o_setup_ok, o_apb_stable;
    bit          o_hung, o_rsp_stable, o_rsp_v, o_psel_resp;
    bit          o_post_valid, o_post_ready;
    logic [15:0] o_paddr;
    logic [3:0]  o_pstrb;
    logic        o_pwrite;
    logic [31:0] o_pwdata, o_rdata;
    logic [1:0]  o_status;
    int          o_acc, o_lat;

    // Drive one command, play slave with 'waits' wait states, hold rsp 'hold' cycles.
    task automatic do_txn(input bit wr, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [3:0] st,
                          input int waits, input bit serr,
                          input logic [31:0] rd, input int hold);
        int  cyc;
        bit  done;
        o_apb_stable  = 1;
        o_rsp_stable  = 1;
        o_ready_start = cmd_ready;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cyc = 1;
        o_setup_ok   = (apb.psel === 1'b1) && (apb.penable === 1'b0);
        o_ready_busy = cmd_ready;
        o_paddr  = apb.paddr;
        o_pstrb  = apb.pstrb;
        o_pwrite = apb.pwrite;
        o_pwdata = apb.pwdata;
        o_acc = 0;
        done  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (apb.penable === 1'b1) begin
                if (apb.psel !== 1'b1 || apb.paddr !== o_paddr ||
                    apb.pstrb !== o_pstrb || apb.pwrite !== o_pwrite ||
                    apb.pwdata !== o_pwdata || apb.pprot !== 3'b000 ||
                    cmd_ready !== 1'b0)
                    o_apb_stable = 0;
                apb.pready  = (o_acc == waits);
                apb.pslverr = (o_acc == waits) ? serr : 1'($urandom);
                apb.prdata  = (o_acc == waits) ? rd : $urandom;
                o_acc++;
            end else begin
                done = 1;
            end
        end
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        o_hung      = !done;
        o_lat       = cyc;
        o_rsp_v     = rsp_valid;
        o_rdata     = rsp_rdata;
        o_status    = rsp_status;
        o_psel_resp = apb.psel | apb.penable;
        if (cmd_ready !== 1'b0) o_rsp_stable = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata ||
                rsp_status !== o_status || cmd_ready !== 1'b0 ||
                apb.psel !== 1'b0)
                o_rsp_stable = 0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o_post_valid = rsp_valid;
        o_post_ready = cmd_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({apb.psel, apb.penable, apb.pwrite, rsp_valid} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {apb.psel, apb.penable, apb.pwrite, rsp_valid});
        end
        checks++;
        if (apb.paddr !== 16'h0 || apb.pstrb !== 4'h0 || apb.pwdata !== 32'h0 ||
            rsp_rdata !== 32'h0 || rsp_status !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: paddr=%h pstrb=%h pwdata=%h rdata=%h st=%0d want all 0",
                     apb.paddr, apb.pstrb, apb.pwdata, rsp_rdata, rsp_status);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        do_txn(1'b1, 16'h0006, 32'h000000a5, 4'hf, 0, 1'b0, 32'hdeadbeef, 0);
        checks++;
        if (!o_setup_ok || o_paddr !== 16'h0004 || o_pstrb !== 4'hf ||
            o_pwrite !== 1'b1 || o_pwdata !== 32'h000000a5) begin
            fails++;
            $display("FAIL wr0_setup: ok=%b paddr=%h pstrb=%h pwrite=%b pwdata=%h want 1 0004 f 1 000000a5",
                     o_setup_ok, o_paddr, o_pstrb, o_pwrite, o_pwdata);
        end
        checks++;
        if (!o_apb_stable || o_acc != 1 || o_lat != 3) begin
            fails++;
            $display("FAIL wr0_timing: stable=%b acc=%0d lat=%0d want 1 1 3",
                     o_apb_stable, o_acc, o_lat);
        end
        checks++;
        if (o_rsp_v !== 1'b1 || o_status !== 2'd0 || o_rdata !== 32'h0) begin
            fails++;
            $display("FAIL wr0_rsp: v=%b st=%0d rdata=%h want 1 0 0",
                     o_rsp_v, o_status, o_rdata);
        end
    endtask

    task automatic test_read_waits();
        do_txn(1'b0, 16'h0123, 32'hffffffff, 4'hf, 3, 1'b0, 32'h12345678, 0);
        checks++;
        if (o_paddr !== 16'h0120 || o_pstrb !== 4'h0 || o_pwrite !== 1'b0 ||
            !o_apb_stable) begin
            fails++;
            $display("FAIL rd3_apb: paddr=%h pstrb=%h pwrite=%b stable=%b want 0120 0 0 1",
                     o_paddr, o_pstrb, o_pwrite, o_apb_stable);
        end
        checks++;
        if (o_acc != 4 || o_lat != 6) begin
            fails++;
            $display("FAIL rd3_penable: acc=%0d lat=%0d want 4 6", o_acc, o_lat);
        end
        checks++;
        if (o_rdata !== 32'h12345678 || o_status !== 2'd0) begin
            fails++;
            $display("FAIL rd3_rsp: rdata=%h st=%0d want 12345678 0", o_rdata, o_status);
        end
    endtask

    task automatic test_slverr();
        do_txn(1'b0, 16'h0040, 32'h0, 4'h0, 1, 1'b1, 32'hcafef00d, 2);
        checks++;
        if (o_status !== 2'd1 || o_rdata !== 32'hcafef00d) begin
            fails++;
            $display("FAIL slverr_rsp: st=%0d rdata=%h want 1 cafef00d", o_status, o_rdata);
        end
        checks++;
        if (!o_rsp_stable || o_post_valid !== 1'b0 || o_post_ready !== 1'b1) begin
            fails++;
            $display("FAIL slverr_hs: stable=%b post_v=%b post_rdy=%b want 1 0 1",
                     o_rsp_stable, o_post_valid, o_post_ready);
        end
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 16'h0200, 32'h0, 4'h0, 99, 1'b0, 32'h5555aaaa, 0);
        checks++;
        if (o_hung || o_acc != TO + 1 || o_psel_resp !== 1'b0) begin
            fails++;
            $display("FAIL timeout_len: hung=%b acc=%0d psel_resp=%b want 0 %0d 0",
                     o_hung, o_acc, o_psel_resp, TO + 1);
        end
        checks++;
        if (o_status !== 2'd2 || o_rdata !== 32'h0) begin
            fails++;
            $display("FAIL timeout_rsp: st=%0d rdata=%h want 2 0", o_status, o_rdata);
        end
        // pready on the very cycle the counter expires must still complete
        do_txn(1'b0, 16'h0204, 32'h0, 4'h0, TO, 1'b0, 32'h0badf00d, 0);
        checks++;
        if (o_status !== 2'd0 || o_rdata !== 32'h0badf00d || o_acc != TO + 1) begin
            fails++;
            $display("FAIL timeout_race: st=%0d rdata=%h acc=%0d want 0 0badf00d %0d",
                     o_status, o_rdata, o_acc, TO + 1);
        end
    endtask

    task automatic test_backpressure();
        do_txn(1'b1, 16'h0010, 32'h87654321, 4'h3, 0, 1'b0, 32'h0, 5);
        checks++;
        if (!o_rsp_stable || o_status !== 2'd0 || o_rdata !== 32'h0) begin
            fails++;
            $display("FAIL backpressure: stable=%b st=%0d rdata=%h want 1 0 0",
                     o_rsp_stable, o_status, o_rdata);
        end
        checks++;
        if (o_post_valid !== 1'b0 || o_post_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: post_v=%b post_rdy=%b want 0 1",
                     o_post_valid, o_post_ready);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0abc;
        cmd_wdata = 32'h11112222;
        cmd_strb  = 4'h5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (apb.penable !== 1'b1) begin
            fails++;
            $display("FAIL midrst_access: penable=%b want 1", apb.penable);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || rsp_valid !== 1'b0 ||
            apb.paddr !== 16'h0 || apb.pstrb !== 4'h0 || apb.pwdata !== 32'h0) begin
            fails++;
            $display("FAIL midrst_abort: psel=%b pen=%b rv=%b paddr=%h pstrb=%h pwdata=%h want all 0",
                     apb.psel, apb.penable, rsp_valid, apb.paddr, apb.pstrb, apb.pwdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_release: rdy=%b rv=%b want 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_random();
        bit          wr, serr;
        logic [15:0] addr;
        logic [31:0] wd, rd, exp_rdata;
        logic [3:0]  st, exp_strb;
        logic [1:0]  exp_status;
        int          waits, hold, exp_acc;
        for (int n = 0; n < 24; n++) begin
            wr    = 1'($urandom);
            serr  = 1'($urandom);
            addr  = 16'($urandom);
            wd    = $urandom;
            rd    = $urandom;
            st    = 4'($urandom);
            waits = $urandom_range(0, 6);
            hold  = $urandom_range(0, 3);
            do_txn(wr, addr, wd, st, waits, serr, rd, hold);
            // Reference: timeout once waits exceed the limit, else pready ends it
            exp_acc    = (waits > TO) ? TO + 1 : waits + 1;
            exp_status = (waits > TO) ? 2'd2 : (serr ? 2'd1 : 2'd0);
            exp_rdata  = (waits > TO || wr) ? 32'h0 : rd;
            exp_strb   = wr ? st : 4'h0;
            checks++;
            if (o_ready_start !== 1'b1 || o_ready_busy !== 1'b0 || !o_setup_ok) begin
                fails++;
                $display("FAIL rnd%0d_hs: rdy0=%b rdy1=%b setup=%b want 1 0 1",
                         n, o_ready_start, o_ready_busy, o_setup_ok);
            end
            checks++;
            if (o_paddr !== {addr[15:2], 2'b00} || o_pstrb !== exp_strb ||
                o_pwrite !== wr || (wr && o_pwdata !== wd) || !o_apb_stable) begin
                fails++;
                $display("FAIL rnd%0d_apb: paddr=%h pstrb=%h pwrite=%b pwdata=%h stable=%b want %h %h %b %h 1",
                         n, o_paddr, o_pstrb, o_pwrite, o_pwdata, o_apb_stable,
                         {addr[15:2], 2'b00}, exp_strb, wr, wd);
            end
            checks++;
            if (o_hung || o_acc != exp_acc || o_lat != exp_acc + 2) begin
                fails++;
                $display("FAIL rnd%0d_timing: hung=%b acc=%0d lat=%0d want 0 %0d %0d",
                         n, o_hung, o_acc, o_lat, exp_acc, exp_acc + 2);
            end
            checks++;
            if (o_rsp_v !== 1'b1 || o_status !== exp_status || o_rdata !== exp_rdata ||
                !o_rsp_stable || o_post_valid !== 1'b0 || o_post_ready !== 1'b1) begin
                fails++;
                $display("FAIL rnd%0d_rsp: v=%b st=%0d rdata=%h stable=%b pv=%b pr=%b want 1 %0d %h 1 0 1",
                         n, o_rsp_v, o_status, o_rdata, o_rsp_stable, o_post_valid,
                         o_post_ready, exp_status, exp_rdata);
            end
        end
    endtask

    initial begin
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
